// File: rtl/aer_rate_encoder_pkg.sv
// rtl/aer_rate_encoder_pkg.sv - shared types and constants for the AER rate encoder
// Contents: encoder FSM states, handshake engine states, marker address default,
//           sigma-delta residue seed helper.
package aer_rate_encoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_EVAL,
        ST_REQ_HI,
        ST_REQ_LO,
        ST_MARK_HI,
        ST_MARK_LO,
        ST_WAIT_CORE
    } enc_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_ARM,
        TX_HI,
        TX_LO
    } tx_state_t;

    localparam logic [11:0] TS_END_ADDR_DEFAULT = 12'hFFF;

    // Half-scale seed: rounds the per-pixel spike count to nearest.
    function automatic int res_init(input int pix_width);
        return 1 << (pix_width - 1);
    endfunction

endpackage

// File: rtl/aer_rate_encoder_if.sv
// rtl/aer_rate_encoder_if.sv - 4-phase AER event bus
// Signals: AERIN_ADDR event address, AERIN_REQ request (master), AERIN_ACK acknowledge (slave).
interface aer_rate_encoder_if #(
    parameter int AER_IN_CORE_WIDTH = 12
) ();
    logic [AER_IN_CORE_WIDTH-1:0] AERIN_ADDR;
    logic                         AERIN_REQ;
    logic                         AERIN_ACK;

    modport master (output AERIN_ADDR, output AERIN_REQ, input AERIN_ACK);
    modport slave  (input AERIN_ADDR, input AERIN_REQ, output AERIN_ACK);
endinterface

// File: rtl/aer_rate_encoder_aer_4phase_tx.sv
// rtl/aer_rate_encoder_aer_4phase_tx.sv - 4-phase request/acknowledge engine with address hold
// Ports: CLK, RST (sync active-high); send/send_addr load a new event; ack from receiver;
//        req/addr drive the bus; hi_done = ack seen while req high; lo_done = ack released.
module aer_4phase_tx
    import aer_rate_encoder_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          send,
    input  logic [AW-1:0] send_addr,
    input  logic          ack,
    output logic          req,
    output logic [AW-1:0] addr,
    output logic          hi_done,
    output logic          lo_done
);
    tx_state_t st;

    assign hi_done = (st == TX_HI) && ack;
    assign lo_done = (st == TX_LO) && !ack;

    always_ff @(posedge CLK) begin
        if (RST) begin
            st   <= TX_IDLE;
            req  <= 1'b0;
            addr <= '0;
        end else if (send) begin
            // send is only issued when idle or on lo_done, so the bus is free here
            addr <= send_addr;
            if (!ack) begin
                req <= 1'b1;
                st  <= TX_HI;
            end else begin
                st  <= TX_ARM;
            end
        end else begin
            case (st)
                TX_ARM: if (!ack) begin
                    req <= 1'b1;
                    st  <= TX_HI;
                end
                TX_HI: if (ack) begin
                    req <= 1'b0;
                    st  <= TX_LO;
                end
                TX_LO: if (!ack) st <= TX_IDLE;
                default: st <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/aer_rate_encoder.sv
// rtl/aer_rate_encoder.sv - sigma-delta rate encoder emitting 4-phase AER spike and marker events
// Ports: CLK, RST (sync active-high); PIX_WR_EN/ADDR/DATA host pixel load (ignored while BUSY);
//        START begins a sample; CORE_DONE sample-finish pulse from the core; aer event bus;
//        BUSY, TS_CNT current step, SAMPLE_DONE completion pulse.
module aer_rate_encoder
    import aer_rate_encoder_pkg::*;
#(
    parameter int TIME_STEP         = 8,
    parameter int INPUT_NEURON      = 784,
    parameter int AER_IN_CORE_WIDTH = 12,
    parameter int PIX_WIDTH         = 8,
    parameter int PIX_ADDR_WIDTH    = 10,
    parameter logic [AER_IN_CORE_WIDTH-1:0] TS_END_ADDR = AER_IN_CORE_WIDTH'(TS_END_ADDR_DEFAULT),
    localparam int TS_W = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      PIX_WR_EN,
    input  logic [PIX_ADDR_WIDTH-1:0] PIX_WR_ADDR,
    input  logic [PIX_WIDTH-1:0]      PIX_WR_DATA,
    input  logic                      START,
    input  logic                      CORE_DONE,
    aer_rate_encoder_if.master        aer,
    output logic                      BUSY,
    output logic [TS_W-1:0]           TS_CNT,
    output logic                      SAMPLE_DONE
);
    localparam logic [PIX_ADDR_WIDTH-1:0] LAST_I   = PIX_ADDR_WIDTH'(INPUT_NEURON - 1);
    localparam logic [TS_W-1:0]           LAST_T   = TS_W'(TIME_STEP - 1);
    localparam logic [PIX_WIDTH-1:0]      RES_INIT = PIX_WIDTH'(res_init(PIX_WIDTH));

    enc_state_t                  state;
    logic [PIX_ADDR_WIDTH-1:0]   i_q;
    logic [TS_W-1:0]             t_q;
    logic                        core_done_flag;

    logic [PIX_WIDTH-1:0] pix_mem [INPUT_NEURON];
    logic [PIX_WIDTH-1:0] res_mem [INPUT_NEURON];
    logic [PIX_WIDTH-1:0] pix_rd;
    logic [PIX_WIDTH-1:0] res_rd;

    logic [PIX_WIDTH-1:0] res_sel;
    logic [PIX_WIDTH:0]   sum;
    logic                 spike;
    logic                 last_i;
    logic                 advance;
    logic                 send_spike;
    logic                 send_mark;
    logic                 tx_send;
    logic [AER_IN_CORE_WIDTH-1:0] tx_addr;
    logic                 tx_hi_done;
    logic                 tx_lo_done;

    // Buffers carry no reset so a loaded sample survives RST.
    always_ff @(posedge CLK) begin
        if (PIX_WR_EN && !BUSY && (PIX_WR_ADDR <= LAST_I))
            pix_mem[PIX_WR_ADDR] <= PIX_WR_DATA;
        pix_rd <= pix_mem[i_q];
    end

    always_ff @(posedge CLK) begin
        if (state == ST_EVAL)
            res_mem[i_q] <= sum[PIX_WIDTH-1:0];
        res_rd <= res_mem[i_q];
    end

    // Step 0 ignores stale residues, which removes the need for a clear pass.
    always_comb begin
        res_sel    = (t_q == '0) ? RES_INIT : res_rd;
        sum        = {1'b0, res_sel} + {1'b0, pix_rd};
        spike      = sum[PIX_WIDTH];
        last_i     = (i_q == LAST_I);
        advance    = ((state == ST_EVAL) && !spike) || ((state == ST_REQ_LO) && tx_lo_done);
        send_spike = (state == ST_EVAL) && spike;
        send_mark  = advance && last_i;
        tx_send    = send_spike || send_mark;
        tx_addr    = send_spike ? AER_IN_CORE_WIDTH'(i_q) : TS_END_ADDR;
    end

    aer_4phase_tx #(.AW(AER_IN_CORE_WIDTH)) u_tx (
        .CLK       (CLK),
        .RST       (RST),
        .send      (tx_send),
        .send_addr (tx_addr),
        .ack       (aer.AERIN_ACK),
        .req       (aer.AERIN_REQ),
        .addr      (aer.AERIN_ADDR),
        .hi_done   (tx_hi_done),
        .lo_done   (tx_lo_done)
    );

    assign TS_CNT = t_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= ST_IDLE;
            i_q            <= '0;
            t_q            <= '0;
            core_done_flag <= 1'b0;
            BUSY           <= 1'b0;
            SAMPLE_DONE    <= 1'b0;
        end else begin
            SAMPLE_DONE <= 1'b0;
            // The core may finish before the last marker; keep its pulse.
            if (BUSY && CORE_DONE)
                core_done_flag <= 1'b1;
            case (state)
                ST_IDLE: if (START) begin
                    i_q            <= '0;
                    t_q            <= '0;
                    core_done_flag <= 1'b0;
                    BUSY           <= 1'b1;
                    state          <= ST_RD;
                end
                ST_RD: state <= ST_EVAL;
                ST_EVAL, ST_REQ_LO: begin
                    if (send_spike) begin
                        state <= ST_REQ_HI;
                    end else if (advance) begin
                        if (last_i) begin
                            state <= ST_MARK_HI;
                        end else begin
                            i_q   <= i_q + 1'b1;
                            state <= ST_RD;
                        end
                    end
                end
                ST_REQ_HI:  if (tx_hi_done) state <= ST_REQ_LO;
                ST_MARK_HI: if (tx_hi_done) state <= ST_MARK_LO;
                ST_MARK_LO: if (tx_lo_done) begin
                    if (t_q != LAST_T) begin
                        t_q   <= t_q + 1'b1;
                        i_q   <= '0;
                        state <= ST_RD;
                    end else begin
                        state <= ST_WAIT_CORE;
                    end
                end
                ST_WAIT_CORE: if (core_done_flag || CORE_DONE) begin
                    SAMPLE_DONE    <= 1'b1;
                    BUSY           <= 1'b0;
                    core_done_flag <= 1'b0;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aer_rate_encoder.sv
// tb/tb_aer_rate_encoder.sv - self-checking bench for aer_rate_encoder
module tb_aer_rate_encoder;
    localparam int T   = 8;
    localparam int N   = 4;
    localparam int AW  = 12;
    localparam int IW  = 2;
    localparam int TSW = 3;
    localparam logic [AW-1:0] MARK = 12'hFFF;

    logic clk = 1'b0;
    logic rst, wr_en, start, core_done;
    logic [IW-1:0] wr_addr;
    logic [7:0] wr_data;
    logic busy, sdone;
    logic [TSW-1:0] ts;

    aer_rate_encoder_if #(.AER_IN_CORE_WIDTH(AW)) aer ();

    aer_rate_encoder #(
        .TIME_STEP(T), .INPUT_NEURON(N), .AER_IN_CORE_WIDTH(AW),
        .PIX_WIDTH(8), .PIX_ADDR_WIDTH(IW), .TS_END_ADDR(MARK)
    ) dut (
        .CLK(clk), .RST(rst), .PIX_WR_EN(wr_en), .PIX_WR_ADDR(wr_addr),
        .PIX_WR_DATA(wr_data), .START(start), .CORE_DONE(core_done), .aer(aer),
        .BUSY(busy), .TS_CNT(ts), .SAMPLE_DONE(sdone)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] ev_q[$];
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] cur_addr;
    int  marks = 0;
    int  ack_dly = 2;
    int  wcnt = 0;
    bit  in_ev = 0;
    int  last_fall_cyc = 0;
    int  done_cnt = 0, done_cyc = 0, marks_at_done = 0, done_base = 0;
    int  pix_m[N];
    int  known_cnt[N] = '{0, 4, 8, 1};

    // Receiver: logs events, checks address hold and REQ-rise rule, returns ACK after ack_dly.
    initial begin
        aer.AERIN_ACK = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aer.AERIN_ACK = 1'b0;
                in_ev = 0;
            end else if (aer.AERIN_REQ && !in_ev) begin
                checks++;
                if (aer.AERIN_ACK !== 1'b0) begin
                    errors++;
                    $display("FAIL req_rise_ack_low: ack=%0b required 0", aer.AERIN_ACK);
                end
                in_ev = 1;
                cur_addr = aer.AERIN_ADDR;
                ev_q.push_back(aer.AERIN_ADDR);
                if (aer.AERIN_ADDR == MARK) marks++;
                wcnt = 0;
                if (ack_dly == 0) aer.AERIN_ACK = 1'b1;
            end else if (in_ev) begin
                if (aer.AERIN_REQ) begin
                    checks++;
                    if (aer.AERIN_ADDR !== cur_addr) begin
                        errors++;
                        $display("FAIL addr_hold: addr=%h required %h", aer.AERIN_ADDR, cur_addr);
                    end
                end
                if (!aer.AERIN_ACK && aer.AERIN_REQ) begin
                    wcnt++;
                    if (wcnt >= ack_dly) aer.AERIN_ACK = 1'b1;
                end else if (aer.AERIN_ACK && !aer.AERIN_REQ) begin
                    aer.AERIN_ACK = 1'b0;
                    in_ev = 0;
                    last_fall_cyc = cyc;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sdone === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                marks_at_done = marks;
            end
        end
    end

    // Reference: per-pixel sigma-delta over T steps, marker closing each step.
    task automatic build_exp();
        int res[N];
        int s;
        exp_q.delete();
        for (int t = 0; t < T; t++) begin
            for (int i = 0; i < N; i++) begin
                s = ((t == 0) ? 128 : res[i]) + pix_m[i];
                if (s >= 256) exp_q.push_back(AW'(i));
                res[i] = s % 256;
            end
            exp_q.push_back(MARK);
        end
    endtask

    function automatic int count_addr(input int a);
        int n = 0;
        foreach (ev_q[k]) if (ev_q[k] == AW'(a)) n++;
        return n;
    endfunction

    function automatic bit seq_ok();
        if (ev_q.size() != exp_q.size()) return 0;
        foreach (exp_q[k]) if (ev_q[k] !== exp_q[k]) return 0;
        return 1;
    endfunction

    task automatic write_pix(input int a, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = IW'(a); wr_data = 8'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_pixels(input int p0, input int p1, input int p2, input int p3);
        int v[N];
        v = '{p0, p1, p2, p3};
        for (int i = 0; i < N; i++) begin
            write_pix(i, v[i]);
            pix_m[i] = v[i];
        end
        build_exp();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_core_done();
        @(negedge clk); core_done = 1'b1;
        @(negedge clk); core_done = 1'b0;
    endtask

    task automatic begin_sample();
        ev_q.delete();
        marks = 0;
        done_base = done_cnt;
        pulse_start();
    endtask

    task automatic finish_sample(input bit send_cd, output bit ok);
        int n = 0;
        while (marks < T && n < 5000) begin @(negedge clk); n++; end
        ok = (marks >= T);
        if (send_cd) pulse_core_done();
        n = 0;
        while (done_cnt == done_base && n < 100) begin @(negedge clk); n++; end
        if (done_cnt == done_base) ok = 0;
    endtask

    task automatic wait_ts(input int v, output bit ok);
        int n = 0;
        while (ts != TSW'(v) && n < 2000) begin @(negedge clk); n++; end
        ok = (ts == TSW'(v));
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; start = 0; core_done = 0;
        repeat (3) @(negedge clk);
        checks++; if (aer.AERIN_REQ !== 1'b0) begin errors++; $display("FAIL reset_req: %b required 0", aer.AERIN_REQ); end
        checks++; if (aer.AERIN_ADDR !== '0) begin errors++; $display("FAIL reset_addr: %h required 0", aer.AERIN_ADDR); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b required 0", busy); end
        checks++; if (ts !== '0) begin errors++; $display("FAIL reset_ts: %0d required 0", ts); end
        checks++; if (sdone !== 1'b0) begin errors++; $display("FAIL reset_done: %b required 0", sdone); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_known_pattern();
        bit ok;
        load_pixels(0, 128, 255, 32);
        begin_sample();
        finish_sample(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL known_timeout: marks=%0d required %0d", marks, T); end
        checks++; if (!seq_ok()) begin errors++; $display("FAIL known_seq: %0d events required %0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (count_addr(i) != known_cnt[i]) begin
                errors++; $display("FAIL known_count[%0d]: %0d required %0d", i, count_addr(i), known_cnt[i]);
            end
        end
        checks++; if (count_addr(MARK) != T) begin errors++; $display("FAIL known_marks: %0d required %0d", count_addr(MARK), T); end
    endtask

    task automatic test_all_zero();
        int n = 0;
        load_pixels(0, 0, 0, 0);
        begin_sample();
        while (marks < T && n < 3000) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        checks++; if (!seq_ok()) begin errors++; $display("FAIL zero_seq: %0d events required %0d", ev_q.size(), exp_q.size()); end
        checks++; if (busy !== 1'b1 || done_cnt != done_base) begin errors++; $display("FAIL zero_wait_core: busy=%b dones=%0d required busy=1 dones=%0d", busy, done_cnt, done_base); end
        pulse_core_done();
        checks++; if (sdone !== 1'b1) begin errors++; $display("FAIL zero_done_pulse: %b required 1", sdone); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_clear: %b required 0", busy); end
        @(negedge clk);
        checks++; if (sdone !== 1'b0) begin errors++; $display("FAIL zero_done_width: %b required 0", sdone); end
    endtask

    task automatic test_early_core_done();
        bit ok, ok2;
        load_pixels(0, 128, 255, 32);
        begin_sample();
        wait_ts(3, ok2);
        pulse_core_done();
        finish_sample(0, ok);
        checks++; if (!(ok && ok2)) begin errors++; $display("FAIL early_timeout: ok=%b ts_ok=%b required 1", ok, ok2); end
        checks++; if (marks_at_done != T) begin errors++; $display("FAIL early_done_marks: %0d required %0d", marks_at_done, T); end
        checks++;
        if (done_cyc - last_fall_cyc > 2 || done_cyc < last_fall_cyc) begin
            errors++; $display("FAIL early_done_latency: %0d cycles required 0..2", done_cyc - last_fall_cyc);
        end
        checks++; if (!seq_ok()) begin errors++; $display("FAIL early_seq: %0d events required %0d", ev_q.size(), exp_q.size()); end
    endtask

    task automatic test_ack_stall();
        bit ok, bad = 0;
        int n = 0;
        logic [AW-1:0] a;
        ack_dly = 50;
        begin_sample();
        while (ev_q.size() < 1 && n < 200) begin @(negedge clk); n++; end
        a = (ev_q.size() > 0) ? ev_q[0] : '1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (aer.AERIN_REQ !== 1'b1 || aer.AERIN_ADDR !== a || ev_q.size() != 1) bad = 1;
        end
        checks++; if (bad) begin errors++; $display("FAIL stall_hold: req=%b addr=%h events=%0d required 1 %h 1", aer.AERIN_REQ, aer.AERIN_ADDR, ev_q.size(), a); end
        finish_sample(1, ok);
        ack_dly = 2;
        checks++; if (!ok || !seq_ok()) begin errors++; $display("FAIL stall_seq: ok=%b events=%0d required 1 %0d", ok, ev_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        begin_sample();
        while (!(ts == 2 && aer.AERIN_REQ === 1'b1) && n < 2000) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (aer.AERIN_REQ !== 1'b0) begin errors++; $display("FAIL rstmid_req: %b required 0", aer.AERIN_REQ); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: %b required 0", busy); end
        checks++; if (ts !== '0) begin errors++; $display("FAIL rstmid_ts: %0d required 0", ts); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        begin_sample();
        finish_sample(1, ok);
        checks++; if (!ok || !seq_ok()) begin errors++; $display("FAIL rstmid_rerun: ok=%b events=%0d required 1 %0d", ok, ev_q.size(), exp_q.size()); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (count_addr(i) != known_cnt[i]) begin
                errors++; $display("FAIL rstmid_count[%0d]: %0d required %0d", i, count_addr(i), known_cnt[i]);
            end
        end
    endtask

    task automatic test_write_while_busy();
        bit ok;
        begin_sample();
        repeat (3) @(negedge clk);
        write_pix(0, 255);
        finish_sample(1, ok);
        checks++; if (!ok || !seq_ok()) begin errors++; $display("FAIL wrbusy_run: ok=%b events=%0d required 1 %0d", ok, ev_q.size(), exp_q.size()); end
        begin_sample();
        finish_sample(1, ok);
        checks++; if (!ok || !seq_ok()) begin errors++; $display("FAIL wrbusy_rerun: ok=%b events=%0d required 1 %0d", ok, ev_q.size(), exp_q.size()); end
        checks++; if (count_addr(0) != 0) begin errors++; $display("FAIL wrbusy_pix0: %0d required 0", count_addr(0)); end
    endtask

    task automatic test_start_while_busy();
        bit ok, ok2;
        begin_sample();
        wait_ts(4, ok2);
        pulse_start();
        checks++; if (ts !== 3'd4 || busy !== 1'b1) begin errors++; $display("FAIL start_busy_ts: ts=%0d busy=%b required 4 1", ts, busy); end
        finish_sample(1, ok);
        checks++; if (!(ok && ok2) || !seq_ok()) begin errors++; $display("FAIL start_busy_seq: ok=%b events=%0d required 1 %0d", ok, ev_q.size(), exp_q.size()); end
    endtask

    task automatic test_random();
        bit ok;
        int want;
        for (int r = 0; r < 3; r++) begin
            ack_dly = $urandom_range(0, 3);
            load_pixels($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            begin_sample();
            finish_sample(1, ok);
            checks++; if (!ok || !seq_ok()) begin errors++; $display("FAIL rand_seq[%0d]: ok=%b events=%0d required 1 %0d", r, ok, ev_q.size(), exp_q.size()); end
            for (int i = 0; i < N; i++) begin
                want = (pix_m[i] * T + 128) / 256;
                checks++;
                if (count_addr(i) != want) begin
                    errors++; $display("FAIL rand_count[%0d][%0d]: %0d required %0d", r, i, count_addr(i), want);
                end
            end
        end
        ack_dly = 2;
    endtask

    initial begin
        test_reset();
        test_known_pattern();
        test_all_zero();
        load_pixels(0, 128, 255, 32);
        test_reset_mid();
        test_early_core_done();
        test_ack_stall();
        test_write_while_busy();
        test_start_while_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
